// File: rtl/ex_mdu_if.sv
// Pipeline-to-MDU handshake bundle for the EX-stage RV32M multiply/divide unit.
// master = EX pipeline control, slave = ex_mdu.
interface ex_mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic [2:0]      md_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, md_op, op_a, op_b,
    input  stall, busy, out_valid, result
  );

  modport slave (
    input  flush, in_valid, md_op, op_a, op_b,
    output stall, busy, out_valid, result
  );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MDU_EARLY_OUT_EN: zero/div-by-zero/overflow cases finish at the accept edge.
module ex_mdu #(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  ex_mdu_if.slave    mdu
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand sign handling at accept
  logic            signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign signed_a = (mdu.md_op == 3'd1) || (mdu.md_op == 3'd2) ||
                    (mdu.md_op == 3'd4) || (mdu.md_op == 3'd6);
  assign signed_b = (mdu.md_op == 3'd1) || (mdu.md_op == 3'd4) || (mdu.md_op == 3'd6);
  assign neg_a    = signed_a & mdu.op_a[XLEN-1];
  assign neg_b    = signed_b & mdu.op_b[XLEN-1];
  assign mag_a    = neg_a ? (~mdu.op_a + 1'b1) : mdu.op_a;
  assign mag_b    = neg_b ? (~mdu.op_b + 1'b1) : mdu.op_b;

  // One multiply step: acc = {product_hi, multiplier_remaining}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

  // One restoring divide step: acc = {remainder, dividend/quotient}
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_borrow;
  logic [2*XLEN-1:0] div_next;

  assign div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, b_q};
  assign div_borrow = div_diff[XLEN+1];
  assign div_next   = div_borrow ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sign correction and result selection
  logic              prod_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_neg = neg_a_q ^ neg_b_q;
  assign prod_fix = prod_neg ? (~acc_q + 1'b1) : acc_q;
  // Divide-by-zero quotient must stay all ones whatever the operand signs.
  assign quo_fix  = div0_q ? '1 :
                    (prod_neg ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0]);
  assign rem_fix  = neg_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = rem_fix;
    case (op_q)
      3'd0:                fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_res = quo_fix;
      default:             fix_res = rem_fix;
    endcase
  end

`ifdef MDU_EARLY_OUT_EN
  logic            early_div0, early_ovf, early_mul0, early_hit;
  logic [XLEN-1:0] early_res;

  assign early_div0 = (mdu.op_b == '0);
  assign early_ovf  = ((mdu.md_op == 3'd4) || (mdu.md_op == 3'd6)) &&
                      (mdu.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.op_b == '1);
  assign early_mul0 = (mdu.op_a == '0) || (mdu.op_b == '0);
  assign early_hit  = mdu.md_op[2] ? (early_div0 | early_ovf) : early_mul0;

  always_comb begin
    early_res = '0;
    if (mdu.md_op[2]) begin
      if (early_div0) early_res = mdu.md_op[1] ? mdu.op_a : '1;
      else            early_res = mdu.md_op[1] ? '0 : mdu.op_a;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (mdu.in_valid) begin
          op_d    = mdu.md_op;
          neg_a_d = neg_a;
          neg_b_d = neg_b;
          div0_d  = (mdu.op_b == '0);
          acc_d   = {{XLEN{1'b0}}, mag_a};
          b_d     = mag_b;
          cnt_d   = '0;
          state_d = StCalc;
`ifdef MDU_EARLY_OUT_EN
          if (early_hit) begin
            result_d = early_res;
            state_d  = StDone;
          end
`endif
        end
      end
      StCalc: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Redirect wins over accept and completion; the last result stays visible.
    if (mdu.flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end

  assign mdu.busy      = (state_q != StIdle);
  assign mdu.out_valid = (state_q == StDone);
  assign mdu.result    = result_q;
  assign mdu.stall     = mdu.in_valid & ~mdu.out_valid & ~mdu.flush;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: arithmetic/latency model plus directed vectors.
// Build with or without MDU_EARLY_OUT_EN; expected latency follows the macro.
module tb_ex_mdu;

  localparam int unsigned XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_mdu_if #(.XLEN(XLEN)) mdu ();

  ex_mdu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // RV32M semantics straight from 64-bit arithmetic
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: p = 64'(sa * sb);
      3'd1: p = 64'(sa * sb) >> 32;
      3'd2: p = 64'(sa * ua) >> 32;
      3'd3: p = 64'(ua * ub) >> 32;
      3'd4: p = (b == 0) ? 64'hFFFF_FFFF : (ovf ? {32'b0, a} : 64'(sa / sb));
      3'd5: p = (b == 0) ? 64'hFFFF_FFFF : 64'(ua / ub);
      3'd6: p = (b == 0) ? {32'b0, a} : (ovf ? 64'd0 : 64'(sa % sb));
      default: p = (b == 0) ? {32'b0, a} : 64'(ua % ub);
    endcase
    return p[31:0];
  endfunction

  function automatic bit model_early(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit ovf;
    ovf = ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (!EarlyEn) return 1'b0;
    return op[2] ? ((b == 0) || ovf) : ((a == 0) || (b == 0));
  endfunction

  // Timing model: out_valid appears XLEN+1 edges after accept (or at once on early-out),
  // lasts one cycle; flush cancels anything in flight.
  int          cyc, m_left, m_acc_cyc;
  bit          m_busy, m_ov;
  logic [31:0] m_pend, m_result;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc       <= 0;
      m_busy    <= 1'b0;
      m_ov      <= 1'b0;
      m_left    <= 0;
      m_acc_cyc <= 0;
      m_pend    <= '0;
      m_result  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (mdu.flush) begin
        m_busy <= 1'b0;
        m_ov   <= 1'b0;
      end else if (m_ov) begin
        m_ov   <= 1'b0;
        m_busy <= 1'b0;
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_ov     <= 1'b1;
          m_result <= m_pend;
        end
      end else if (mdu.in_valid) begin
        m_busy    <= 1'b1;
        m_acc_cyc <= cyc + 1;
        m_pend    <= model_res(mdu.md_op, mdu.op_a, mdu.op_b);
        if (model_early(mdu.md_op, mdu.op_a, mdu.op_b)) begin
          m_ov     <= 1'b1;
          m_result <= model_res(mdu.md_op, mdu.op_a, mdu.op_b);
          m_left   <= 0;
        end else begin
          m_left <= XLEN + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("busy", 32'(mdu.busy), 32'(m_busy));
      chk("out_valid", 32'(mdu.out_valid), 32'(m_ov));
      chk("result", mdu.result, m_result);
      chk("stall", 32'(mdu.stall), 32'(mdu.in_valid & ~m_ov & ~mdu.flush));
    end
  end

  task automatic wait_ov(input string name, output int c);
    c = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (mdu.out_valid) begin
        c = cyc;
        break;
      end
    end
    n_chk++;
    if (c < 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got no out_valid expected out_valid within 200 cycles", name);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu.md_op    = op;
    mdu.op_a     = a;
    mdu.op_b     = b;
    mdu.in_valid = 1'b1;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        early;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec] = '{
    '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0},
    '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{3'd0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b1},
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0},
    '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1},
    '{3'd6, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1},
    '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0},
    '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0}
  };

  initial begin
    int c, c1, c2, exp_lat;
    mdu.flush    = 1'b0;
    mdu.in_valid = 1'b0;
    mdu.md_op    = '0;
    mdu.op_a     = '0;
    mdu.op_b     = '0;

    #3;
    chk("reset_busy", 32'(mdu.busy), 32'd0);
    chk("reset_out_valid", 32'(mdu.out_valid), 32'd0);
    chk("reset_result", mdu.result, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      #1 issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_ov($sformatf("vec%0d", i), c);
      chk($sformatf("vec%0d_result", i), mdu.result, vecs[i].exp);
      chk($sformatf("vec%0d_model", i), model_res(vecs[i].op, vecs[i].a, vecs[i].b),
          vecs[i].exp);
      exp_lat = (EarlyEn && vecs[i].early) ? 0 : XLEN + 1;
      chk($sformatf("vec%0d_edges_after_accept", i), 32'(c - m_acc_cyc), 32'(exp_lat));
      mdu.in_valid = 1'b0;
    end

    // Flush 10 cycles into a multiply: nothing is delivered, old result (2) stays.
    @(negedge clk);
    #1 issue(3'd0, 32'h0000_1234, 32'h0000_0010);
    repeat (11) @(negedge clk);
    #1;
    mdu.flush    = 1'b1;
    mdu.in_valid = 1'b0;
    @(negedge clk);
    #1 mdu.flush = 1'b0;
    chk("flush_busy", 32'(mdu.busy), 32'd0);
    chk("flush_out_valid", 32'(mdu.out_valid), 32'd0);
    chk("flush_result", mdu.result, 32'd2);
    repeat (40) @(negedge clk);
    #1 issue(3'd5, 32'd9, 32'd3);
    wait_ov("after_flush", c);
    chk("after_flush_result", mdu.result, 32'd3);
    mdu.in_valid = 1'b0;

    // Asynchronous reset mid-CALC clears everything at once.
    @(negedge clk);
    #1 issue(3'd0, 32'd3, 32'd5);
    repeat (6) @(negedge clk);
    #1;
    mdu.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    chk("midrst_busy", 32'(mdu.busy), 32'd0);
    chk("midrst_out_valid", 32'(mdu.out_valid), 32'd0);
    chk("midrst_result", mdu.result, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Back-to-back with in_valid held: second accept on the edge after DONE->IDLE.
    @(negedge clk);
    #1 issue(3'd0, 32'd3, 32'd5);
    wait_ov("b2b_first", c1);
    chk("b2b_first_result", mdu.result, 32'd15);
    mdu.op_a = 32'd6;
    mdu.op_b = 32'd7;
    wait_ov("b2b_second", c2);
    chk("b2b_second_result", mdu.result, 32'd42);
    chk("b2b_spacing", 32'(c2 - c1), 32'(2 + XLEN + 1));
    mdu.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
